pipelined_rca_adder: RTL and testbench

//  Parametrised, pipelined ripple-carry adder: WIDTH-bit operands split into SEG_W-bit

---
 rtl/pipelined_rca_adder.sv | 159 +++++++++++++++
 tb/tb_pipelined_rca_adder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder: one SEG_W-bit segment per stage, valid/ready with full backpressure.
// Optional ADDER_DMR_EN adds a duplicate adder per stage whose mismatches are reported on out_err.
module pipelined_rca_adder #(
  parameter int WIDTH = 16,
  parameter int SEG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic                     cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         sum,
  output logic                     cout,
  output logic                     ovf,
  output logic                     out_err,
  output logic                     fault_sticky,
  input  logic                     fault_clr,
  input  logic [WIDTH/SEG_W-1:0]   fi_mask
);

  localparam int NSEG = WIDTH / SEG_W;

  logic adv;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = stg[NSEG-1].v_q;

  for (genvar k = 0; k < NSEG; k++) begin : stg
    localparam int IN_W   = WIDTH - k * SEG_W;
    localparam int DONE_W = (k + 1) * SEG_W;

    logic [IN_W-1:0]   a_in;
    logic [IN_W-1:0]   b_in;
    logic              c_in;
    logic              v_in;
    logic [DONE_W-1:0] s_next;
    logic [DONE_W-1:0] s_q;
    logic [SEG_W:0]    seg_p;
    logic [SEG_W-1:0]  seg_out;
    logic              c_q;
    logic              v_q;

    // Operands shrink by one segment per stage; the summed part grows by one.
    if (k == 0) begin : src
      assign a_in   = a;
      assign b_in   = b;
      assign c_in   = cin;
      assign v_in   = in_valid;
      assign s_next = seg_out;
    end else begin : src
      assign a_in   = stg[k-1].rem.a_q;
      assign b_in   = stg[k-1].rem.b_q;
      assign c_in   = stg[k-1].c_q;
      assign v_in   = stg[k-1].v_q;
      assign s_next = {seg_out, stg[k-1].s_q};
    end

    assign seg_p   = {1'b0, a_in[SEG_W-1:0]} + {1'b0, b_in[SEG_W-1:0]} + (SEG_W+1)'(c_in);
    assign seg_out = seg_p[SEG_W-1:0] ^ SEG_W'(fi_mask[k]);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_in;
        if (v_in) begin
          c_q <= seg_p[SEG_W];
          s_q <= s_next;
        end
      end
    end

    if (k < NSEG - 1) begin : rem
      logic [IN_W-SEG_W-1:0] a_q;
      logic [IN_W-SEG_W-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv && v_in) begin
          a_q <= a_in[IN_W-1:SEG_W];
          b_q <= b_in[IN_W-1:SEG_W];
        end
      end
    end else begin : fin
      logic o_q;

      // Carry into the MSB is recovered from the unfaulted segment sum.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          o_q <= 1'b0;
        end else if (adv && v_in) begin
          o_q <= (a_in[SEG_W-1] ^ b_in[SEG_W-1] ^ seg_p[SEG_W-1]) ^ seg_p[SEG_W];
        end
      end
    end

`ifdef ADDER_DMR_EN
    logic [SEG_W:0] dup;
    logic           rc;
    logic           e_in;
    logic           e_q;

    if (k == 0) begin : esrc
      assign e_in = 1'b0;
    end else begin : esrc
      assign e_in = stg[k-1].e_q;
    end

    // Shadow adder is a gate-level ripple so it shares no structure with seg_p.
    always_comb begin
      rc  = c_in;
      dup = '0;
      for (int i = 0; i < SEG_W; i++) begin
        dup[i] = a_in[i] ^ b_in[i] ^ rc;
        rc     = (a_in[i] & b_in[i]) | (rc & (a_in[i] ^ b_in[i]));
      end
      dup[SEG_W] = rc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        e_q <= 1'b0;
      end else if (adv && v_in) begin
        e_q <= e_in | (dup != {seg_p[SEG_W], seg_out});
      end
    end
`endif
  end

  assign sum  = stg[NSEG-1].s_q;
  assign cout = stg[NSEG-1].c_q;
  assign ovf  = stg[NSEG-1].fin.o_q;

`ifdef ADDER_DMR_EN
  assign out_err = stg[NSEG-1].e_q;
`else
  assign out_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_sticky <= 1'b0;
    end else if (fault_clr) begin
      fault_sticky <= 1'b0;
    end else if (out_valid && out_ready && out_err) begin
      fault_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Self-checking bench for pipelined_rca_adder: directed cases plus randomized streaming
// against an arithmetic reference model with a queue scoreboard.
module tb_pipelined_rca_adder;

  localparam int WIDTH = 16;
  localparam int SEG_W = 4;
  localparam int NSEG  = WIDTH / SEG_W;

`ifdef ADDER_DMR_EN
  localparam bit DMR = 1'b1;
`else
  localparam bit DMR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             out_err;
  logic             fault_sticky;
  logic             fault_clr;
  logic [NSEG-1:0]  fi_mask;

  int          checkCount = 0;
  int          failCount  = 0;
  int          inCount    = 0;
  int          outCount   = 0;
  bit          lastInHs;
  bit          lastOutValid;
  logic [18:0] expQ[$];

  pipelined_rca_adder #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .out_err(out_err),
    .fault_sticky(fault_sticky), .fault_clr(fault_clr), .fi_mask(fi_mask)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Packed as {err, ovf, cout, sum}; fault injection flips segment LSBs after the true add.
  function automatic logic [18:0] refAdd(input logic [15:0] x, input logic [15:0] y,
                                         input logic c, input logic [3:0] m);
    logic [16:0] full;
    logic [15:0] s;
    logic        v;
    full = {1'b0, x} + {1'b0, y} + 17'(c);
    s    = full[15:0];
    v    = (x[15] == y[15]) && (s[15] != x[15]);
    for (int k = 0; k < 4; k++) begin
      if (m[k]) s[k*4] = ~s[k*4];
    end
    return {DMR && (m != 4'b0), v, full[16], s};
  endfunction

  task automatic applyStimulus(input logic v, input logic [15:0] x, input logic [15:0] y,
                               input logic c, input logic ordy);
    @(negedge clk);
    in_valid  = v;
    a         = x;
    b         = y;
    cin       = c;
    out_ready = ordy;
    #1;
    lastOutValid = out_valid;
    lastInHs     = in_valid && in_ready;
    checkOutput("in_ready", {31'b0, in_ready}, {31'b0, (out_valid ? out_ready : 1'b1)});
    if (out_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious_valid", {31'b0, out_valid}, 32'd0);
      end else begin
        checkOutput("result", {13'b0, out_err, ovf, cout, sum}, {13'b0, expQ[0]});
        if (out_ready) begin
          void'(expQ.pop_front());
          outCount++;
        end
      end
    end
    if (lastInHs) begin
      expQ.push_back(refAdd(x, y, c, fi_mask));
      inCount++;
    end
  endtask

  task automatic sendAndWait(input string tag, input logic [15:0] x, input logic [15:0] y,
                             input logic c, input logic [18:0] expv);
    bit found = 1'b0;
    applyStimulus(1'b1, x, y, c, 1'b1);
    for (int i = 1; i <= 3 * NSEG && !found; i++) begin
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      if (lastOutValid) begin
        found = 1'b1;
        checkOutput({tag, "_latency"}, i, NSEG);
        checkOutput(tag, {13'b0, out_err, ovf, cout, sum}, {13'b0, expv});
      end
    end
    if (!found) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    logic [15:0] ta[8];
    logic [15:0] tb[8];
    int          idx;
    int          startOut;
    int          cyc;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b0;
    fault_clr = 1'b0;
    fi_mask   = '0;
    #12;
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset_outputs", {13'b0, out_err, ovf, cout, sum}, 32'd0);
    checkOutput("reset_sticky", {31'b0, fault_sticky}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed arithmetic and wrap cases.
    sendAndWait("t1_basic", 16'h1234, 16'h4321, 1'b0, 19'h05555);
    sendAndWait("t2_wrap",  16'hFFFF, 16'h0000, 1'b1, 19'h10000);
    sendAndWait("t2_ovf",   16'h7FFF, 16'h0001, 1'b0, 19'h28000);
    sendAndWait("t2_negov", 16'h8000, 16'h8000, 1'b0, 19'h30000);

    // Back-to-back stream with a three-cycle output stall.
    for (int i = 0; i < 8; i++) begin
      ta[i] = 16'($urandom);
      tb[i] = 16'($urandom);
    end
    idx      = 0;
    startOut = outCount;
    cyc      = 0;
    while (outCount < startOut + 8 && cyc < 60) begin
      applyStimulus(idx < 8, (idx < 8) ? ta[idx] : 16'h0, (idx < 8) ? tb[idx] : 16'h0,
                    1'b0, !(cyc >= 5 && cyc <= 7));
      if (cyc == 6) checkOutput("t3_stall_in_ready", {31'b0, in_ready}, 32'd0);
      if (lastInHs) idx++;
      cyc++;
    end
    checkOutput("t3_count", outCount - startOut, 8);
    checkOutput("t3_queue_empty", expQ.size(), 0);

    // Reset with three items in flight.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b1);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("t4_reset_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("t4_reset_outputs", {13'b0, out_err, ovf, cout, sum}, 32'd0);
    expQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2 * NSEG; i++) begin
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      checkOutput("t4_no_stale_valid", {31'b0, out_valid}, 32'd0);
    end

    // Fault injection into segment 2 and sticky flag behaviour.
    fi_mask = 4'b0100;
    sendAndWait("t5_fault", 16'h0001, 16'h0001, 1'b0, {DMR, 18'h00102});
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    checkOutput("t5_sticky_set", {31'b0, fault_sticky}, {31'b0, DMR});
    fault_clr = 1'b1;
    @(posedge clk);
    #1;
    fault_clr = 1'b0;
    checkOutput("t5_sticky_clr", {31'b0, fault_sticky}, 32'd0);
    applyStimulus(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0);
    for (int i = 0; i < NSEG + 1; i++) applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    fault_clr = 1'b1;
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    fault_clr = 1'b0;
    checkOutput("t5_clr_priority", {31'b0, fault_sticky}, 32'd0);
    checkOutput("t5_queue_empty", expQ.size(), 0);
    fi_mask = '0;

    // Random streaming with random backpressure.
    startOut = outCount;
    idx      = inCount;
    cyc      = 0;
    while (inCount < idx + 10000 && cyc < 60000) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 7))
        0: ra = 16'hFFFF;
        1: rb = 16'h8000;
        default: ;
      endcase
      applyStimulus($urandom_range(0, 3) != 0, ra, rb, 1'($urandom), $urandom_range(0, 3) != 0);
      cyc++;
    end
    for (int i = 0; i < 4 * NSEG && expQ.size() != 0; i++)
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    checkOutput("t6_accepted", inCount - idx, 10000);
    checkOutput("t6_drained", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
